// File: rtl/mips_exec_unit.sv
// Execute stage for the multicycle MIPS core: ALU control, ALU, branch adder.
// Results are exposed combinationally and held in ALUOut/target registers.
module mips_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] offset,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] add_out,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q,
    output logic [WIDTH-1:0] add_out_q
);

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_XOR  = 4'b0011;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SLTU = 4'b1000;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_BAD  = 4'b1111;

    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic [WIDTH-1:0] add_out_d;

    always_comb begin
        alu_ctrl = CTRL_BAD;
        unique case (alu_op)
            2'b00: alu_ctrl = CTRL_ADD;
            2'b01: alu_ctrl = CTRL_SUB;
            2'b11: alu_ctrl = CTRL_OR;
            2'b10: begin
                unique case (func_code)
                    6'b100000, 6'b100001: alu_ctrl = CTRL_ADD;
                    6'b100010, 6'b100011: alu_ctrl = CTRL_SUB;
                    6'b100100: alu_ctrl = CTRL_AND;
                    6'b100101: alu_ctrl = CTRL_OR;
                    6'b100110: alu_ctrl = CTRL_XOR;
                    6'b100111: alu_ctrl = CTRL_NOR;
                    6'b101010: alu_ctrl = CTRL_SLT;
                    6'b101011: alu_ctrl = CTRL_SLTU;
                    default:   alu_ctrl = CTRL_BAD;
                endcase
            end
            default: alu_ctrl = CTRL_BAD;
        endcase
    end

    always_comb begin
        result = '0;
        unique case (alu_ctrl)
            CTRL_AND:  result = a & b;
            CTRL_OR:   result = a | b;
            CTRL_ADD:  result = a + b;
            CTRL_XOR:  result = a ^ b;
            CTRL_SUB:  result = a - b;
            CTRL_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            CTRL_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
            CTRL_NOR:  result = ~(a | b);
            default:   result = '0;
        endcase
    end

    assign zero    = (result == '0);
    assign add_out = pc_in + offset;

    always_comb begin
        result_d  = result_q;
        zero_d    = zero_q;
        add_out_d = add_out_q;
        if (en) begin
            result_d  = result;
            zero_d    = zero;
            add_out_d = add_out;
        end
    end

    // Reset wins over en on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            add_out_q <= '0;
        end else begin
            result_q  <= result_d;
            zero_q    <= zero_d;
            add_out_q <= add_out_d;
        end
    end

endmodule

// File: tb/tb_mips_exec_unit.sv
// Self-checking bench for mips_exec_unit: directed plan cases plus
// randomized traffic against a behavioural model.
module tb_mips_exec_unit;

    logic        clk = 1'b0;
    logic        reset, en;
    logic [1:0]  alu_op;
    logic [5:0]  func_code;
    logic [31:0] a, b, pc_in, offset;
    logic [3:0]  alu_ctrl;
    logic [31:0] result, add_out, result_q, add_out_q;
    logic        zero, zero_q;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .en(en),
        .alu_op(alu_op), .func_code(func_code),
        .a(a), .b(b), .pc_in(pc_in), .offset(offset),
        .alu_ctrl(alu_ctrl), .result(result), .zero(zero),
        .add_out(add_out), .result_q(result_q),
        .zero_q(zero_q), .add_out_q(add_out_q)
    );

    function automatic logic [3:0] m_ctrl(input logic [1:0] op,
                                          input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        case (f)
            6'h20, 6'h21: return 4'b0010;
            6'h22, 6'h23: return 4'b0110;
            6'h24: return 4'b0000;
            6'h25: return 4'b0001;
            6'h26: return 4'b0011;
            6'h27: return 4'b1100;
            6'h2a: return 4'b0111;
            6'h2b: return 4'b1000;
            default: return 4'b1111;
        endcase
    endfunction

    // Result straight from the instruction semantics, independent of ctrl codes.
    function automatic logic [31:0] m_res(input logic [1:0] op,
                                          input logic [5:0] f,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == 2'b00) return 32'(x + y);
        if (op == 2'b01) return 32'(x - y);
        if (op == 2'b11) return x | y;
        case (f)
            6'h20, 6'h21: return 32'(x + y);
            6'h22, 6'h23: return 32'(x - y);
            6'h24: return x & y;
            6'h25: return x | y;
            6'h26: return x ^ y;
            6'h27: return ~(x | y);
            6'h2a: return (sx < sy) ? 32'd1 : 32'd0;
            6'h2b: return ({32'd0, x} < {32'd0, y}) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] x, input logic [31:0] y);
        alu_op = op; func_code = f; a = x; b = y;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1;
        drive(2'b00, 6'h0, 32'd7, 32'd9);
        pc_in = 32'h100; offset = 32'h4;
        @(posedge clk); #1;
        n_tests++;
        if (result_q !== 32'd0 || zero_q !== 1'b0 || add_out_q !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_q: got %h/%b/%h want 0/0/0", result_q, zero_q, add_out_q);
        end
        n_tests++;
        if (result !== 32'd16) begin
            n_fail++;
            $display("FAIL reset_comb: got %h want 00000010", result);
        end
        reset = 1'b0; en = 1'b0;
    endtask

    task automatic test_add_wrap();
        drive(2'b10, 6'h20, 32'hFFFFFFFF, 32'd1);
        n_tests++;
        if (alu_ctrl !== 4'b0010 || result !== 32'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL add_wrap: got %b/%h/%b want 0010/0/1", alu_ctrl, result, zero);
        end
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        n_tests++;
        if (result_q !== 32'd0 || zero_q !== 1'b1) begin
            n_fail++;
            $display("FAIL add_wrap_q: got %h/%b want 0/1", result_q, zero_q);
        end
    endtask

    task automatic test_slt();
        drive(2'b10, 6'h2a, 32'hFFFFFFFE, 32'd3);
        n_tests++;
        if (alu_ctrl !== 4'b0111 || result !== 32'd1 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL slt: got %b/%h/%b want 0111/1/0", alu_ctrl, result, zero);
        end
        drive(2'b10, 6'h2b, 32'hFFFFFFFE, 32'd3);
        n_tests++;
        if (alu_ctrl !== 4'b1000 || result !== 32'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL sltu: got %b/%h/%b want 1000/0/1", alu_ctrl, result, zero);
        end
    endtask

    task automatic test_sub();
        drive(2'b01, 6'h3f, 32'd5, 32'd5);
        n_tests++;
        if (alu_ctrl !== 4'b0110 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_eq: got %b/%b want 0110/1", alu_ctrl, zero);
        end
        drive(2'b01, 6'h3f, 32'd5, 32'd6);
        n_tests++;
        if (result !== 32'hFFFFFFFF || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_neg: got %h/%b want ffffffff/0", result, zero);
        end
    endtask

    task automatic test_nor_bad();
        drive(2'b10, 6'h27, 32'h0F0F0000, 32'h000000F0);
        n_tests++;
        if (alu_ctrl !== 4'b1100 || result !== 32'hF0F0FF0F) begin
            n_fail++;
            $display("FAIL nor: got %b/%h want 1100/f0f0ff0f", alu_ctrl, result);
        end
        drive(2'b10, 6'h3f, 32'h0F0F0000, 32'h000000F0);
        n_tests++;
        if (alu_ctrl !== 4'b1111 || result !== 32'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_funct: got %b/%h/%b want 1111/0/1", alu_ctrl, result, zero);
        end
        drive(2'b11, 6'h00, 32'h00F0_0000, 32'h0000_1234);
        n_tests++;
        if (alu_ctrl !== 4'b0001 || result !== 32'h00F01234) begin
            n_fail++;
            $display("FAIL ori: got %b/%h want 0001/00f01234", alu_ctrl, result);
        end
    endtask

    task automatic test_branch_adder();
        pc_in = 32'hBFC00000; offset = 32'h10; #1;
        n_tests++;
        if (add_out !== 32'hBFC00010) begin
            n_fail++;
            $display("FAIL br_add: got %h want bfc00010", add_out);
        end
        pc_in = 32'hFFFFFFFC; offset = 32'd8; #1;
        n_tests++;
        if (add_out !== 32'd4) begin
            n_fail++;
            $display("FAIL br_wrap: got %h want 00000004", add_out);
        end
    endtask

    task automatic test_hold_and_reset();
        drive(2'b00, 6'h0, 32'd100, 32'd23);
        pc_in = 32'h400; offset = 32'h20;
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        drive(2'b01, 6'h0, 32'd1, 32'd1);
        pc_in = 32'h0; offset = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (result_q !== 32'd123 || zero_q !== 1'b0 || add_out_q !== 32'h420) begin
            n_fail++;
            $display("FAIL hold: got %h/%b/%h want 7b/0/420", result_q, zero_q, add_out_q);
        end
        drive(2'b00, 6'h0, 32'd1, 32'd1);
        reset = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (result_q !== 32'd0 || zero_q !== 1'b0 || add_out_q !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_prio: got %h/%b/%h want 0/0/0", result_q, zero_q, add_out_q);
        end
        reset = 1'b0; en = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0]  valid_f [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                      6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
        logic [31:0] er, ea;
        logic [31:0] mq_r = result_q;
        logic [31:0] mq_a = add_out_q;
        logic        mq_z = zero_q;
        logic [5:0]  f;
        for (int i = 0; i < 300; i++) begin
            f = ($urandom_range(3) == 0) ? 6'($urandom) : valid_f[$urandom_range(9)];
            pc_in  = $urandom;
            offset = $urandom << 2;
            case ($urandom_range(3))
                0: drive(2'($urandom), f, $urandom, $urandom);
                1: drive(2'($urandom), f, 32'($urandom_range(4)), 32'($urandom_range(4)));
                2: begin
                    a = $urandom;
                    drive(2'($urandom), f, a, a);
                end
                default: drive(2'($urandom), f, {1'b1, 31'($urandom)}, $urandom);
            endcase
            er = m_res(alu_op, func_code, a, b);
            ea = pc_in + offset;
            n_tests++;
            if (alu_ctrl !== m_ctrl(alu_op, func_code) || result !== er ||
                zero !== (er == 32'd0) || add_out !== ea) begin
                n_fail++;
                $display("FAIL rand_comb op=%b f=%h a=%h b=%h: got %b/%h/%b/%h want %b/%h/%b/%h",
                         alu_op, func_code, a, b, alu_ctrl, result, zero, add_out,
                         m_ctrl(alu_op, func_code), er, (er == 32'd0), ea);
            end
            en = 1'($urandom);
            if (en) begin
                mq_r = er; mq_z = (er == 32'd0); mq_a = ea;
            end
            @(posedge clk); #1;
            n_tests++;
            if (result_q !== mq_r || zero_q !== mq_z || add_out_q !== mq_a) begin
                n_fail++;
                $display("FAIL rand_q: got %h/%b/%h want %h/%b/%h",
                         result_q, zero_q, add_out_q, mq_r, mq_z, mq_a);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0;
        alu_op = '0; func_code = '0; a = '0; b = '0; pc_in = '0; offset = '0;
        #2;
        test_reset();
        test_add_wrap();
        test_slt();
        test_sub();
        test_nor_bad();
        test_branch_adder();
        test_hold_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
